// File: rtl/button_mode_ctrl.sv
// Two-button RUN/SET/LOCK mode controller with field editing, idle timeout
// and blink generation. Each output is a flop, so it changes on the edge after its input code.
module button_mode_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned BLINK_HALF  = 12_500_000,
  parameter int unsigned NUM_FIELDS  = 3
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [1:0] btn_a_code,
  input  logic [1:0] btn_b_code,
  output logic [1:0] mode,
  output logic [1:0] field,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       page_pulse,
  output logic       commit_pulse,
  output logic       cancel_pulse,
  output logic       blink
);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_SET  = 2'b01;
  localparam logic [1:0] MODE_LOCK = 2'b10;

  localparam int unsigned IDLE_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [1:0]         FIELD_LAST = 2'(NUM_FIELDS - 1);

  logic [1:0]         mode_q, mode_d;
  logic [1:0]         field_q, field_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               page_q, page_d;
  logic               commit_q, commit_d;
  logic               cancel_q, cancel_d;

  logic a_short, a_long, a_evt, b_short, b_long, any_evt;

  // Code 11 decodes as no event; a coincident A event masks B.
  always_comb begin
    a_short = (btn_a_code == 2'b01);
    a_long  = (btn_a_code == 2'b10);
    a_evt   = a_short | a_long;
    b_short = !a_evt && (btn_b_code == 2'b01);
    b_long  = !a_evt && (btn_b_code == 2'b10);
    any_evt = a_evt | b_short | b_long;
  end

  always_comb begin
    mode_d      = mode_q;
    field_d     = field_q;
    idle_d      = idle_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    page_d      = 1'b0;
    commit_d    = 1'b0;
    cancel_d    = 1'b0;

    case (mode_q)
      MODE_RUN: begin
        if (a_long) begin
          mode_d      = MODE_SET;
          field_d     = 2'd0;
          idle_d      = '0;
          blink_cnt_d = '0;
          blink_d     = 1'b1;
        end else if (b_short) begin
          page_d = 1'b1;
        end else if (b_long) begin
          mode_d = MODE_LOCK;
        end
      end

      MODE_SET: begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end

        if (any_evt) begin
          idle_d = '0;
        end else if (idle_q != IDLE_LAST) begin
          idle_d = idle_q + 1'b1;
        end

        // Exits below override the counter updates above.
        if (a_short) begin
          if (field_q >= FIELD_LAST) begin
            commit_d = 1'b1;
            mode_d   = MODE_RUN;
          end else begin
            field_d     = field_q + 2'd1;
            blink_cnt_d = '0;
            blink_d     = 1'b1;
          end
        end else if (a_long) begin
          cancel_d = 1'b1;
          mode_d   = MODE_RUN;
        end else if (b_short) begin
          inc_d = 1'b1;
        end else if (b_long) begin
          dec_d = 1'b1;
        end else if (idle_q == IDLE_LAST) begin
          cancel_d = 1'b1;
          mode_d   = MODE_RUN;
        end

        if (mode_d == MODE_RUN) begin
          field_d     = 2'd0;
          idle_d      = '0;
          blink_cnt_d = '0;
          blink_d     = 1'b0;
        end
      end

      MODE_LOCK: begin
        if (b_long) mode_d = MODE_RUN;
      end

      default: begin
        mode_d      = MODE_RUN;
        field_d     = 2'd0;
        idle_d      = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_RUN;
      field_q     <= 2'd0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      page_q      <= 1'b0;
      commit_q    <= 1'b0;
      cancel_q    <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      field_q     <= field_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      page_q      <= page_d;
      commit_q    <= commit_d;
      cancel_q    <= cancel_d;
    end
  end

  assign mode         = mode_q;
  assign field        = field_q;
  assign inc_pulse    = inc_q;
  assign dec_pulse    = dec_q;
  assign page_pulse   = page_q;
  assign commit_pulse = commit_q;
  assign cancel_pulse = cancel_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Self-checking bench for button_mode_ctrl: directed vector table, multi-cycle
// timeout/reset sequences, and random events scored against a behavioural model.
module tb_button_mode_ctrl;

  localparam int unsigned TO = 100;
  localparam int unsigned BH = 10;
  localparam int unsigned NF = 3;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn_a_code = 2'b00, btn_b_code = 2'b00;
  logic [1:0] mode, field;
  logic       inc_pulse, dec_pulse, page_pulse, commit_pulse, cancel_pulse, blink;

  logic [1:0] a1_code = 2'b00, b1_code = 2'b00;
  logic [1:0] mode1, field1;
  logic       inc1, dec1, page1, commit1, cancel1, blink1;

  int total = 0;
  int bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  button_mode_ctrl #(.TIMEOUT_CYC(TO), .BLINK_HALF(BH), .NUM_FIELDS(NF)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .btn_a_code(btn_a_code), .btn_b_code(btn_b_code),
    .mode(mode), .field(field), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .page_pulse(page_pulse), .commit_pulse(commit_pulse), .cancel_pulse(cancel_pulse),
    .blink(blink)
  );

  button_mode_ctrl #(.TIMEOUT_CYC(TO), .BLINK_HALF(BH), .NUM_FIELDS(1)) dut1 (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .btn_a_code(a1_code), .btn_b_code(b1_code),
    .mode(mode1), .field(field1), .inc_pulse(inc1), .dec_pulse(dec1),
    .page_pulse(page1), .commit_pulse(commit1), .cancel_pulse(cancel1), .blink(blink1)
  );

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] m;
    logic [1:0] f;
    logic [4:0] p;  // {inc, dec, page, commit, cancel}
    logic       bl;
  } vec_t;

  vec_t tbl[23];

  // Behavioural model: mode 0 RUN, 1 SET, 2 LOCK; ages counted in plain integers.
  int         m_mode, m_field, m_idle, m_bage;
  logic [4:0] e_p;

  task automatic model_reset();
    m_mode = 0; m_field = 0; m_idle = 0; m_bage = 0; e_p = 5'b0;
  endtask

  task automatic model_step(input logic [1:0] a, input logic [1:0] b);
    bit as, al, bs, bl, ev;
    as = (a == 2'b01);
    al = (a == 2'b10);
    bs = !(as || al) && (b == 2'b01);
    bl = !(as || al) && (b == 2'b10);
    ev = as || al || bs || bl;
    e_p = 5'b0;
    if (m_mode == 0) begin
      if (al) begin m_mode = 1; m_field = 0; m_idle = 0; m_bage = 0; end
      else if (bs) e_p = 5'b00100;
      else if (bl) m_mode = 2;
    end else if (m_mode == 1) begin
      if (!ev && m_idle == TO - 1) begin
        e_p = 5'b00001; m_mode = 0; m_field = 0;
      end else begin
        m_idle = ev ? 0 : m_idle + 1;
        m_bage++;
        if (as) begin
          if (m_field == NF - 1) begin e_p = 5'b00010; m_mode = 0; m_field = 0; end
          else begin m_field++; m_bage = 0; end
        end else if (al) begin
          e_p = 5'b00001; m_mode = 0; m_field = 0;
        end else if (bs) e_p = 5'b10000;
        else if (bl) e_p = 5'b01000;
      end
    end else begin
      if (bl) m_mode = 0;
    end
  endtask

  function automatic logic model_blink();
    return (m_mode == 1) && ((m_bage / BH) % 2 == 0);
  endfunction

  task automatic check(input string name, input logic [1:0] em, input logic [1:0] ef,
                       input logic [4:0] ep, input logic eb);
    logic [9:0] got, exp;
    got = {mode, field, inc_pulse, dec_pulse, page_pulse, commit_pulse, cancel_pulse, blink};
    exp = {em, ef, ep, eb};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got mode=%b field=%0d pulses=%b blink=%b, want mode=%b field=%0d pulses=%b blink=%b",
               name, got[9:8], got[7:6], got[5:1], got[0], em, ef, ep, eb);
    end
  endtask

  task automatic check1(input string name, input logic [1:0] em, input logic ecommit);
    total++;
    if (mode1 !== em || commit1 !== ecommit || field1 !== 2'd0) begin
      bad++;
      $display("FAIL %s: got mode=%b commit=%b field=%0d, want mode=%b commit=%b field=0",
               name, mode1, commit1, field1, em, ecommit);
    end
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b);
    btn_a_code = a;
    btn_b_code = b;
    @(posedge CLOCK_50);
    #1;
    btn_a_code = 2'b00; btn_b_code = 2'b00;
    a1_code = 2'b00; b1_code = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b10, 2'b00, 2'b01, 2'd0, 5'b00000, 1'b1};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 2'd1, 5'b00000, 1'b1};
    tbl[2]  = '{2'b01, 2'b00, 2'b01, 2'd2, 5'b00000, 1'b1};
    tbl[3]  = '{2'b01, 2'b00, 2'b00, 2'd0, 5'b00010, 1'b0};
    tbl[4]  = '{2'b00, 2'b00, 2'b00, 2'd0, 5'b00000, 1'b0};
    tbl[5]  = '{2'b10, 2'b00, 2'b01, 2'd0, 5'b00000, 1'b1};
    tbl[6]  = '{2'b00, 2'b01, 2'b01, 2'd0, 5'b10000, 1'b1};
    tbl[7]  = '{2'b00, 2'b00, 2'b01, 2'd0, 5'b00000, 1'b1};
    tbl[8]  = '{2'b00, 2'b10, 2'b01, 2'd0, 5'b01000, 1'b1};
    tbl[9]  = '{2'b01, 2'b01, 2'b01, 2'd1, 5'b00000, 1'b1};
    tbl[10] = '{2'b11, 2'b00, 2'b01, 2'd1, 5'b00000, 1'b1};
    tbl[11] = '{2'b00, 2'b11, 2'b01, 2'd1, 5'b00000, 1'b1};
    tbl[12] = '{2'b11, 2'b01, 2'b01, 2'd1, 5'b10000, 1'b1};
    tbl[13] = '{2'b10, 2'b00, 2'b00, 2'd0, 5'b00001, 1'b0};
    tbl[14] = '{2'b00, 2'b01, 2'b00, 2'd0, 5'b00100, 1'b0};
    tbl[15] = '{2'b00, 2'b10, 2'b10, 2'd0, 5'b00000, 1'b0};
    tbl[16] = '{2'b10, 2'b00, 2'b10, 2'd0, 5'b00000, 1'b0};
    tbl[17] = '{2'b01, 2'b00, 2'b10, 2'd0, 5'b00000, 1'b0};
    tbl[18] = '{2'b00, 2'b01, 2'b10, 2'd0, 5'b00000, 1'b0};
    tbl[19] = '{2'b01, 2'b10, 2'b10, 2'd0, 5'b00000, 1'b0};
    tbl[20] = '{2'b00, 2'b10, 2'b00, 2'd0, 5'b00000, 1'b0};
    tbl[21] = '{2'b01, 2'b00, 2'b00, 2'd0, 5'b00000, 1'b0};
    tbl[22] = '{2'b00, 2'b00, 2'b00, 2'd0, 5'b00000, 1'b0};

    do_reset();
    check("reset_state", 2'b00, 2'd0, 5'b0, 1'b0);
    check1("nf1_reset", 2'b00, 1'b0);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d", i), tbl[i].m, tbl[i].f, tbl[i].p, tbl[i].bl);
    end

    // Single-field instance commits on the first A short.
    a1_code = 2'b10; step(2'b00, 2'b00);
    check1("nf1_enter", 2'b01, 1'b0);
    a1_code = 2'b01; step(2'b00, 2'b00);
    check1("nf1_commit", 2'b00, 1'b1);

    // Idle timeout with blink cadence.
    do_reset();
    step(2'b10, 2'b00);
    check("to_entry", 2'b01, 2'd0, 5'b0, 1'b1);
    for (int i = 1; i <= 100; i++) begin
      step(2'b00, 2'b00);
      if (i == 9 || i == 10 || i == 20 || i == 55)
        check($sformatf("to_blink%0d", i), 2'b01, 2'd0, 5'b0, ((i / 10) % 2 == 0));
      if (i == 99) check("to_last_set", 2'b01, 2'd0, 5'b0, 1'b0);
      if (i == 100) check("to_expire", 2'b00, 2'd0, 5'b00001, 1'b0);
    end
    step(2'b00, 2'b00);
    check("to_pulse_gone", 2'b00, 2'd0, 5'b0, 1'b0);

    // Event in the timeout cycle wins and restarts the idle count.
    step(2'b10, 2'b00);
    for (int i = 1; i <= 99; i++) step(2'b00, 2'b00);
    step(2'b00, 2'b01);
    check("to_evt_wins", 2'b01, 2'd0, 5'b10000, 1'b1);
    for (int i = 1; i <= 99; i++) step(2'b00, 2'b00);
    check("to_restart_set", 2'b01, 2'd0, 5'b0, 1'b0);
    step(2'b00, 2'b00);
    check("to_restart_expire", 2'b00, 2'd0, 5'b00001, 1'b0);

    // Asynchronous reset mid-SET between clock edges.
    step(2'b10, 2'b00);
    step(2'b01, 2'b00);
    check("mid_set", 2'b01, 2'd1, 5'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 2'b00, 2'd0, 5'b0, 1'b0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("async_reset_held", 2'b00, 2'd0, 5'b0, 1'b0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    model_reset();
    step(2'b00, 2'b00);
    check("after_reset_idle", 2'b00, 2'd0, 5'b0, 1'b0);
    step(2'b10, 2'b00);
    check("first_evt_after_reset", 2'b01, 2'd0, 5'b0, 1'b1);

    // Randomized events against the model: dense then sparse to reach timeouts.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int ra, rb, span;
      logic [1:0] a, b;
      span = (n < 2000) ? 40 : 400;
      ra = $urandom_range(0, span - 1);
      rb = $urandom_range(0, span - 1);
      a = (ra < 4) ? ra[1:0] : 2'b00;
      b = (rb < 4) ? rb[1:0] : 2'b00;
      if (n % 7 == 0 && ra < 8) a = ra[1:0];
      model_step(a, b);
      step(a, b);
      check($sformatf("rand%0d", n), 2'(m_mode), 2'(m_field), e_p, model_blink());
      total++;
      if ($countones({inc_pulse, dec_pulse, page_pulse, commit_pulse, cancel_pulse}) > 1) begin
        bad++;
        $display("FAIL rand_onehot%0d: got pulses=%b, want at most one high", n,
                 {inc_pulse, dec_pulse, page_pulse, commit_pulse, cancel_pulse});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_mode_ctrl.md
BUTTON_MODE_CTRL -- requirements
Module: button_mode_ctrl

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- TIMEOUT_CYC, 500_000_000, idle cycles in SET/LOCK-entry before auto-exit (10 s at 50 MHz).
- BLINK_HALF, 12_500_000, blink half-period in cycles (250 ms).
- NUM_FIELDS, 3, editable fields in SET mode; legal range 1..4.

REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- CLOCK_50, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- btn_a_code, in, 2, event code from button A decoder: 00 none, 01 short, 10 long, 11 illegal.
- btn_b_code, in, 2, event code from button B decoder, same encoding.
- mode, out, 2, 00 RUN, 01 SET, 10 LOCK.
- field, out, 2, selected field in SET; 0 otherwise.
- inc_pulse, out, 1, one-cycle increment of selected field.
- dec_pulse, out, 1, one-cycle decrement of selected field.
- page_pulse, out, 1, one-cycle advance of display page.
- commit_pulse, out, 1, one-cycle commit of edited values.
- cancel_pulse, out, 1, one-cycle discard of edited values.
- blink, out, 1, blanking enable for the selected field.

REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 Event codes SHALL be single-cycle. Each nonzero code SHALL be consumed exactly once, in the cycle it is present.
REQ-005 Code 11 SHALL be treated as 00.
REQ-006 If A and B events coincide, the A event SHALL be processed and the B event discarded.
REQ-007 All outputs SHALL be registered. Pulses and state changes SHALL appear one cycle after the input code cycle.
REQ-008 Pulse outputs SHALL be high for exactly one cycle. At most one pulse SHALL be high in any cycle.
REQ-009 RUN transitions:
- A long -> SET, field=0.
- B short -> page_pulse.
- B long -> LOCK.
- A short -> ignored.
REQ-010 SET transitions:
- A short with field<NUM_FIELDS-1 -> field+1.
- A short with field=NUM_FIELDS-1 -> RUN, commit_pulse, field=0.
- A long -> RUN, cancel_pulse, field=0.
- B short -> inc_pulse.
- B long -> dec_pulse.
REQ-011 LOCK transitions: B long -> RUN; all other events SHALL be ignored without pulses.
REQ-012 Idle counter behaviour:
- Counts cycles in SET.
- Clears on any consumed event and on SET entry.
- Reaching TIMEOUT_CYC-1 -> RUN, cancel_pulse, field=0.
- The counter SHALL NOT wrap and SHALL be sized for TIMEOUT_CYC.
REQ-013 An event arriving in the timeout cycle SHALL take priority over the timeout. The timeout SHALL be suppressed and the counter cleared.
REQ-014 Blink behaviour:
- In SET, blink SHALL toggle every BLINK_HALF cycles, starting at 1 on SET entry.
- The blink counter SHALL restart on every field change.
- blink SHALL be 0 in RUN and LOCK.
REQ-015 With NUM_FIELDS=1, an A short in SET SHALL commit immediately.
REQ-016 No state SHALL be reachable other than RUN, SET and LOCK. Any illegal encoding SHALL recover to RUN on the next cycle.

Reset
REQ-017 While rst_n=0, the block SHALL hold the following values, independent of CLOCK_50:
- mode=00, field=0, all pulses 0, blink=0.
- Idle and blink counters = 0.
REQ-018 Reset asserted mid-SET SHALL discard edits without cancel_pulse. After release the block SHALL be in RUN.
REQ-019 The first event after rst_n rises SHALL be processed normally on the following edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then A=10 for one cycle -> next cycle mode=01, field=0, blink=1. Then A=01 three times -> field 1, field 2, then mode=00 with commit_pulse high for one cycle.
- In SET: B=01 -> inc_pulse for one cycle. B=10 -> dec_pulse for one cycle. A=10 -> mode=00, cancel_pulse.
- RUN: B=10 -> mode=10. Then A=10, A=01 and B=01 -> no change, no pulses. Then B=10 -> mode=00.
- TIMEOUT_CYC=100 and BLINK_HALF=10: enter SET, idle -> blink toggles every 10 cycles; at idle cycle 99, mode=00 and cancel_pulse. Repeat with B=01 at cycle 99 -> inc_pulse, mode stays 01.
- In SET, A=01 and B=01 in the same cycle -> field advances, no inc_pulse. Code 11 on either input -> no effect.
- Assert rst_n=0 mid-SET between clock edges -> outputs immediately at reset values, no cancel_pulse.
